cordic_pipe: RTL and testbench

CORDIC_PIPE -- requirements
Module: cordic_pipe

---
 rtl/cordic_pipe.sv | 102 ++++++++++
 tb/tb_cordic_pipe.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_pipe.sv
// cordic_pipe: pipelined CORDIC rotator/vectorer; define CORDIC_GAIN_COMP_EN to fold ~0.6074 gain compensation into the pre-rotation stage
module cordic_pipe #(
    parameter int DATA_W  = 16,
    parameter int ANGLE_W = 32,
    parameter int STAGES  = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      mode,
    input  logic signed [DATA_W-1:0]  x_in,
    input  logic signed [DATA_W-1:0]  y_in,
    input  logic signed [ANGLE_W-1:0] z_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [DATA_W+1:0]  x_out,
    output logic signed [DATA_W+1:0]  y_out,
    output logic signed [ANGLE_W-1:0] z_out,
    output logic                      mode_out
);
    localparam int W = DATA_W + 2;
    localparam logic signed [ANGLE_W-1:0] QTR = ANGLE_W'(1) << (ANGLE_W - 2);
    localparam logic [31:0] ATAN [24] = '{
        32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
        32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
        32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
        32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
        32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
        32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051
    };
    logic                      adv;
    logic [STAGES:0]           vs, ms;
    logic signed [W-1:0]       xs [STAGES+1];
    logic signed [W-1:0]       ys [STAGES+1];
    logic signed [ANGLE_W-1:0] zs [STAGES+1];
    logic signed [W-1:0]       nx [STAGES+1];
    logic signed [W-1:0]       ny [STAGES+1];
    logic signed [ANGLE_W-1:0] nz [STAGES+1];
    logic signed [W-1:0]       xe, ye, px, py;
    logic signed [ANGLE_W-1:0] pz;
    logic [1:0]                q;
    logic                      xn, yn;
    assign adv       = !vs[STAGES] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vs[STAGES];
    assign mode_out  = ms[STAGES];
    assign x_out     = xs[STAGES];
    assign y_out     = ys[STAGES];
    assign z_out     = zs[STAGES];
    assign xe = {{2{x_in[DATA_W-1]}}, x_in};
    assign ye = {{2{y_in[DATA_W-1]}}, y_in};
    // pre-rotation folds the input into the +/-90 deg range the micro-rotations can reach
    always_comb begin
        q  = z_in[ANGLE_W-1:ANGLE_W-2];
        xn = xe[W-1];
        yn = ye[W-1];
        px = mode ? (!xn ? xe : yn ? -ye : ye) : (q == 2'b01 ? -ye : q == 2'b10 ? ye : xe);
        py = mode ? (!xn ? ye : yn ? xe : -xe) : (q == 2'b01 ? xe : q == 2'b10 ? -xe : ye);
        pz = mode ? (!xn ? '0 : yn ? -QTR : QTR) : (q == 2'b01 ? z_in - QTR : q == 2'b10 ? z_in + QTR : z_in);
    end
`ifdef CORDIC_GAIN_COMP_EN
    assign nx[0] = (px >>> 1) + (px >>> 3) - (px >>> 6) - (px >>> 9);
    assign ny[0] = (py >>> 1) + (py >>> 3) - (py >>> 6) - (py >>> 9);
`else
    assign nx[0] = px;
    assign ny[0] = py;
`endif
    assign nz[0] = pz;
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        localparam logic signed [31:0] A32 = ATAN[i];
        localparam logic signed [ANGLE_W-1:0] A = ANGLE_W'(A32 >>> (32 - ANGLE_W));
        logic d;
        logic signed [W-1:0] xsh, ysh;
        assign d       = ms[i] ? ys[i][W-1] : !zs[i][ANGLE_W-1];
        assign xsh     = xs[i] >>> i;
        assign ysh     = ys[i] >>> i;
        assign nx[i+1] = d ? xs[i] - ysh : xs[i] + ysh;
        assign ny[i+1] = d ? ys[i] + xsh : ys[i] - xsh;
        assign nz[i+1] = d ? zs[i] - A : zs[i] + A;
    end
    // whole pipe advances in lockstep; a stalled output freezes every stage
    always_ff @(posedge clock) begin
        if (reset) begin
            vs <= '0;
            ms <= '0;
            for (int k = 0; k <= STAGES; k++) begin
                xs[k] <= '0;
                ys[k] <= '0;
                zs[k] <= '0;
            end
        end else if (adv) begin
            vs <= {vs[STAGES-1:0], in_valid};
            ms <= {ms[STAGES-1:0], mode};
            for (int k = 0; k <= STAGES; k++) begin
                xs[k] <= nx[k];
                ys[k] <= ny[k];
                zs[k] <= nz[k];
            end
        end
    end
endmodule

// File: tb/tb_cordic_pipe.sv
// tb_cordic_pipe: directed and streamed checks of cordic_pipe in both gain configurations
module tb_cordic_pipe;
    localparam int DW = 16;
    localparam int AW = 32;
    localparam int NS = 16;
    localparam int W  = DW + 2;
`ifdef CORDIC_GAIN_COMP_EN
    localparam real GAIN = 0.607421875 * 1.6467602581;
    localparam real TOL  = 8.0;
`else
    localparam real GAIN = 1.6467602581;
    localparam real TOL  = 16.0;
`endif
    localparam logic [31:0] AT [24] = '{
        32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
        32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
        32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
        32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
        32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
        32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051
    };
    logic clock = 0;
    logic reset = 1;
    logic in_valid = 0;
    logic mode = 0;
    logic out_ready = 1;
    logic in_ready, out_valid, mode_out;
    logic signed [DW-1:0] x_in = '0;
    logic signed [DW-1:0] y_in = '0;
    logic signed [AW-1:0] z_in = '0;
    logic signed [W-1:0] x_out, y_out;
    logic signed [AW-1:0] z_out;
    int n_cmp = 0;
    int n_bad = 0;

    cordic_pipe #(.DATA_W(DW), .ANGLE_W(AW), .STAGES(NS)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .x_out(x_out), .y_out(y_out), .z_out(z_out), .mode_out(mode_out)
    );

    always #5 clock = ~clock;

    function automatic void model(input logic m, input logic signed [DW-1:0] xi, input logic signed [DW-1:0] yi,
                                  input logic signed [AW-1:0] zi, output logic signed [W-1:0] xo,
                                  output logic signed [W-1:0] yo, output logic signed [AW-1:0] zo);
        logic signed [W-1:0] x, y, t;
        logic signed [AW-1:0] z, a;
        x = {{2{xi[DW-1]}}, xi};
        y = {{2{yi[DW-1]}}, yi};
        z = 0;
        if (m) begin
            if (x < 0) begin
                t = x;
                if (y < 0) begin x = -y; y = t; z = -32'sh40000000; end
                else begin x = y; y = -t; z = 32'sh40000000; end
            end
        end else begin
            z = zi;
            if (zi[31:30] == 2'b01) begin t = x; x = -y; y = t; z = zi - 32'sh40000000; end
            else if (zi[31:30] == 2'b10) begin t = x; x = y; y = -t; z = zi + 32'sh40000000; end
        end
`ifdef CORDIC_GAIN_COMP_EN
        x = (x >>> 1) + (x >>> 3) - (x >>> 6) - (x >>> 9);
        y = (y >>> 1) + (y >>> 3) - (y >>> 6) - (y >>> 9);
`endif
        for (int i = 0; i < NS; i++) begin
            a = AT[i];
            t = x;
            if (m ? (y < 0) : (z >= 0)) begin x = x - (y >>> i); y = y + (t >>> i); z = z - a; end
            else begin x = x + (y >>> i); y = y - (t >>> i); z = z + a; end
        end
        xo = x;
        yo = y;
        zo = z;
    endfunction

    task automatic run_one(input logic m, input logic signed [DW-1:0] xi, input logic signed [DW-1:0] yi,
                           input logic signed [AW-1:0] zi, output logic signed [W-1:0] rx,
                           output logic signed [W-1:0] ry, output logic signed [AW-1:0] rz,
                           output logic rm, output int lat);
        @(posedge clock); #1;
        mode = m; x_in = xi; y_in = yi; z_in = zi; in_valid = 1; out_ready = 1;
        lat = 0;
        do begin
            @(posedge clock); #1;
            lat++;
            in_valid = 0;
        end while (!out_valid && lat < 100);
        rx = x_out; ry = y_out; rz = z_out; rm = mode_out;
    endtask

    task automatic test_reset();
        logic seen;
        reset = 1; in_valid = 1; x_in = 100; mode = 0; out_ready = 0;
        @(posedge clock); #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        @(posedge clock); #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++;
        if (x_out !== '0 || y_out !== '0) begin n_bad++; $display("FAIL reset_xy: got %0d,%0d want 0,0", x_out, y_out); end
        n_cmp++;
        if (z_out !== '0 || mode_out !== 1'b0) begin n_bad++; $display("FAIL reset_z_mode: got %0d,%b want 0,0", z_out, mode_out); end
        reset = 0; in_valid = 0; out_ready = 1;
        seen = 0;
        repeat (25) begin @(posedge clock); #1; if (out_valid) seen = 1; end
        n_cmp++;
        if (seen !== 1'b0) begin n_bad++; $display("FAIL reset_sample_dropped: got out_valid=%b want 0", seen); end
    endtask

    task automatic test_rotation();
        logic [31:0] zt [5] = '{32'h20000000, 32'h80000000, 32'h00000000, 32'h60000000, 32'hC0000000};
        real ux [5] = '{11585.24, -16384.0, 16384.0, -11585.24, 0.0};
        real uy [5] = '{11585.24, 0.0, 0.0, 11585.24, -16384.0};
        logic signed [W-1:0] rx, ry, ex, ey;
        logic signed [AW-1:0] rz, ez, dz;
        logic rm;
        int lat;
        real dv;
        for (int k = 0; k < 5; k++) begin
            run_one(1'b0, 16'sd16384, 16'sd0, zt[k], rx, ry, rz, rm, lat);
            model(1'b0, 16'sd16384, 16'sd0, zt[k], ex, ey, ez);
            n_cmp++;
            if (lat != NS + 1) begin n_bad++; $display("FAIL rot%0d_latency: got %0d want %0d", k, lat, NS + 1); end
            dv = $itor(rx) - ux[k] * GAIN;
            n_cmp++;
            if (dv > TOL || dv < -TOL) begin n_bad++; $display("FAIL rot%0d_x: got %0d want %0.1f", k, rx, ux[k] * GAIN); end
            dv = $itor(ry) - uy[k] * GAIN;
            n_cmp++;
            if (dv > TOL || dv < -TOL) begin n_bad++; $display("FAIL rot%0d_y: got %0d want %0.1f", k, ry, uy[k] * GAIN); end
            dz = rz;
            n_cmp++;
            if (dz > 32'sd262144 || dz < -32'sd262144) begin n_bad++; $display("FAIL rot%0d_z: got %0d want 0", k, rz); end
            n_cmp++;
            if (rx !== ex || ry !== ey || rz !== ez || rm !== 1'b0) begin
                n_bad++; $display("FAIL rot%0d_exact: got %0d,%0d,%0d,%b want %0d,%0d,%0d,0", k, rx, ry, rz, rm, ex, ey, ez);
            end
        end
    endtask

    task automatic test_vectoring();
        logic signed [DW-1:0] vx [4] = '{16'sd10000, -16'sd10000, -16'sd10000, 16'sd0};
        logic signed [DW-1:0] vy [4] = '{16'sd10000, 16'sd0, -16'sd10000, 16'sd5000};
        real ux [4] = '{14142.14, 10000.0, 14142.14, 5000.0};
        logic [31:0] zt [4] = '{32'h20000000, 32'h80000000, 32'hA0000000, 32'h40000000};
        logic signed [W-1:0] rx, ry, ex, ey;
        logic signed [AW-1:0] rz, ez, dz;
        logic rm;
        int lat;
        real dv;
        for (int k = 0; k < 4; k++) begin
            run_one(1'b1, vx[k], vy[k], 32'h7FFF0000, rx, ry, rz, rm, lat);
            model(1'b1, vx[k], vy[k], 32'h7FFF0000, ex, ey, ez);
            dv = $itor(rx) - ux[k] * GAIN;
            n_cmp++;
            if (dv > TOL || dv < -TOL) begin n_bad++; $display("FAIL vec%0d_x: got %0d want %0.1f", k, rx, ux[k] * GAIN); end
            dv = $itor(ry);
            n_cmp++;
            if (dv > TOL || dv < -TOL) begin n_bad++; $display("FAIL vec%0d_y: got %0d want 0", k, ry); end
            dz = rz - zt[k];
            n_cmp++;
            if (dz > 32'sd262144 || dz < -32'sd262144) begin n_bad++; $display("FAIL vec%0d_z: got %h want %h", k, rz, zt[k]); end
            n_cmp++;
            if (rx !== ex || ry !== ey || rz !== ez || rm !== 1'b1) begin
                n_bad++; $display("FAIL vec%0d_exact: got %0d,%0d,%0d,%b want %0d,%0d,%0d,1", k, rx, ry, rz, rm, ex, ey, ez);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic signed [W-1:0] ax, ay, bx, by;
        logic signed [AW-1:0] az, bz;
        int cyc;
        @(posedge clock); #1;
        out_ready = 1;
        mode = 0; x_in = 16'sd12000; y_in = -16'sd3000; z_in = 32'h12345678; in_valid = 1;
        model(mode, x_in, y_in, z_in, ax, ay, az);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_a: got %b want 1", in_ready); end
        @(posedge clock); #1;
        mode = 1; x_in = -16'sd7000; y_in = 16'sd9000; z_in = 32'h0; in_valid = 1;
        model(mode, x_in, y_in, z_in, bx, by, bz);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_b: got %b want 1", in_ready); end
        @(posedge clock); #1;
        in_valid = 0;
        cyc = 2;
        while (!out_valid && cyc < 100) begin @(posedge clock); #1; cyc++; end
        n_cmp++;
        if (cyc != NS + 1) begin n_bad++; $display("FAIL b2b_latency: got %0d want %0d", cyc, NS + 1); end
        n_cmp++;
        if (x_out !== ax || y_out !== ay || z_out !== az || mode_out !== 1'b0) begin
            n_bad++; $display("FAIL b2b_first: got %0d,%0d,%0d,%b want %0d,%0d,%0d,0", x_out, y_out, z_out, mode_out, ax, ay, az);
        end
        @(posedge clock); #1;
        n_cmp++;
        if (out_valid !== 1'b1 || x_out !== bx || y_out !== by || z_out !== bz || mode_out !== 1'b1) begin
            n_bad++; $display("FAIL b2b_second: got v=%b %0d,%0d,%0d,%b want v=1 %0d,%0d,%0d,1", out_valid, x_out, y_out, z_out, mode_out, bx, by, bz);
        end
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic test_stream();
        logic signed [W-1:0] qx [$];
        logic signed [W-1:0] qy [$];
        logic signed [AW-1:0] qz [$];
        logic qm [$];
        logic signed [W-1:0] sx, sy, ex, ey;
        logic signed [AW-1:0] sz, ez;
        logic sm, acc, cons, stall, em;
        int sent, got, cyc;
        sent = 0; got = 0; cyc = 0; acc = 0;
        @(posedge clock); #1;
        in_valid = 0;
        while (got < 40 && cyc < 3000) begin
            if (!in_valid || acc) begin
                if (sent < 40 && $urandom_range(0, 3) != 0) begin
                    in_valid = 1; mode = 1'($urandom_range(0, 1));
                    x_in = 16'($urandom); y_in = 16'($urandom); z_in = $urandom;
                end else in_valid = 0;
            end
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clock);
            acc = in_valid && in_ready;
            cons = out_valid && out_ready;
            stall = out_valid && !out_ready;
            sx = x_out; sy = y_out; sz = z_out; sm = mode_out;
            if (acc) begin
                model(mode, x_in, y_in, z_in, ex, ey, ez);
                qx.push_back(ex); qy.push_back(ey); qz.push_back(ez); qm.push_back(mode);
                sent++;
            end
            @(posedge clock); #1;
            cyc++;
            if (cons) begin
                n_cmp++;
                if (qx.size() == 0) begin
                    n_bad++; $display("FAIL stream_extra: got output %0d with nothing pending", sx);
                end else begin
                    ex = qx.pop_front(); ey = qy.pop_front(); ez = qz.pop_front(); em = qm.pop_front();
                    if (sx !== ex || sy !== ey || sz !== ez || sm !== em) begin
                        n_bad++; $display("FAIL stream_out%0d: got %0d,%0d,%0d,%b want %0d,%0d,%0d,%b", got, sx, sy, sz, sm, ex, ey, ez, em);
                    end
                end
                got++;
            end
            if (stall) begin
                n_cmp++;
                if (out_valid !== 1'b1 || x_out !== sx || y_out !== sy || z_out !== sz || mode_out !== sm) begin
                    n_bad++; $display("FAIL stream_hold: got v=%b %0d,%0d,%0d want v=1 %0d,%0d,%0d", out_valid, x_out, y_out, z_out, sx, sy, sz);
                end
            end
        end
        in_valid = 0; out_ready = 1;
        n_cmp++;
        if (got != 40 || qx.size() != 0) begin n_bad++; $display("FAIL stream_count: got %0d out, %0d pending want 40, 0", got, qx.size()); end
        repeat (NS + 3) @(posedge clock);
        #1;
    endtask

    task automatic test_reset_midflight();
        logic seen, rm;
        logic signed [W-1:0] rx, ry, ex, ey;
        logic signed [AW-1:0] rz, ez;
        int lat;
        @(posedge clock); #1;
        out_ready = 1;
        for (int k = 0; k < 5; k++) begin
            mode = k[0]; x_in = 16'(1000 * (k + 1)); y_in = 16'(-500 * k); z_in = 32'(k) << 28; in_valid = 1;
            @(posedge clock); #1;
        end
        reset = 1; x_in = 16'sd1234;
        @(posedge clock); #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_valid: got %b want 0", out_valid); end
        n_cmp++;
        if (x_out !== '0 || z_out !== '0 || mode_out !== 1'b0) begin n_bad++; $display("FAIL midreset_data: got %0d,%0d,%b want 0,0,0", x_out, z_out, mode_out); end
        reset = 0; in_valid = 0;
        seen = 0;
        repeat (25) begin @(posedge clock); #1; if (out_valid) seen = 1; end
        n_cmp++;
        if (seen !== 1'b0) begin n_bad++; $display("FAIL midreset_stale: got out_valid=%b want 0", seen); end
        run_one(1'b0, 16'sd16384, 16'sd0, 32'h20000000, rx, ry, rz, rm, lat);
        model(1'b0, 16'sd16384, 16'sd0, 32'h20000000, ex, ey, ez);
        n_cmp++;
        if (lat != NS + 1) begin n_bad++; $display("FAIL midreset_latency: got %0d want %0d", lat, NS + 1); end
        n_cmp++;
        if (rx !== ex || ry !== ey || rz !== ez) begin n_bad++; $display("FAIL midreset_result: got %0d,%0d,%0d want %0d,%0d,%0d", rx, ry, rz, ex, ey, ez); end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_vectoring();
        test_back_to_back();
        test_stream();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
